// File: rtl/pkg_parameters.sv
// Shared types and constants for the unified instruction/data memory arbiter.
// Provides the response-owner encoding, the default starvation limit and a
// helper that sizes the starvation counter.
package pkg_parameters;

    // Which requester receives the read data returning from the RAM this cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } resp_owner_e;

    // Default number of denied fetch cycles tolerated before fetch is promoted
    localparam int unsigned ARB_STARVE_LIMIT = 4;

    // Counter width able to hold 0..limit; keeps at least one bit when the
    // guard is disabled so the register never collapses to zero width.
    function automatic int unsigned starve_cnt_width(input int unsigned limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Denied-cycle counters for the memory port arbiter. Two free-running 32-bit
// counters that wrap naturally; only built when ARB_PERF_CNT_EN is defined.
module mem_arb_perf_cnt (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_stall_i,
    input  logic        dm_stall_i,
    output logic [31:0] if_cnt_o,
    output logic [31:0] dm_cnt_o
);

    logic [31:0] if_cnt_reg;
    logic [31:0] dm_cnt_reg;

    // Count every cycle in which a requester asked and was turned away
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_cnt_reg <= '0;
            dm_cnt_reg <= '0;
        end else begin
            if (if_stall_i) if_cnt_reg <= if_cnt_reg + 32'd1;
            if (dm_stall_i) dm_cnt_reg <= dm_cnt_reg + 32'd1;
        end
    end

    assign if_cnt_o = if_cnt_reg;
    assign dm_cnt_o = dm_cnt_reg;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between instruction fetch
// (IF) and the load/store unit (DM). Grants are combinational, one per cycle,
// with DM preferred unless fetch has been starved for STARVE_LIMIT cycles.
// Read data returning one cycle later is steered to the requester that
// issued it; a fetch response is suppressed by a flush in either the grant
// or the response cycle.
// Optional feature: define ARB_PERF_CNT_EN to build the denied-cycle counters.
module mem_port_arbiter
    import pkg_parameters::*;
#(
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    // instruction fetch port
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    input  logic                    if_flush_i,
    output logic                    if_gnt_o,
    output logic                    if_rvalid_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    // load/store port
    input  logic                    dm_req_i,
    input  logic                    dm_we_i,
    input  logic [DATA_WIDTH/8-1:0] dm_be_i,
    input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
    input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
    output logic                    dm_gnt_o,
    output logic                    dm_rvalid_o,
    output logic [DATA_WIDTH-1:0]   dm_rdata_o,
    // RAM port
    output logic                    mem_en_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    // performance counters
    output logic [31:0]             perf_if_stall_o,
    output logic [31:0]             perf_dm_stall_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_W    = starve_cnt_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic             starve_flag;
    logic             if_gnt;
    logic             dm_gnt;
    logic             dm_store;
    resp_owner_e      owner_reg;
    resp_owner_e      owner_next;
    logic             flush_q_reg;
    logic [CNT_W-1:0] starve_cnt_reg;
    logic [CNT_W-1:0] starve_cnt_next;

    // Pick at most one winner; nobody is granted while reset is held
    always_comb begin
        starve_flag = (STARVE_LIMIT != 0) && (starve_cnt_reg == STARVE_MAX);
        if_gnt      = 1'b0;
        dm_gnt      = 1'b0;
        if (!rst_i) begin
            if (starve_flag && if_req_i) begin
                if_gnt = 1'b1;
            end else if (dm_req_i) begin
                dm_gnt = 1'b1;
            end else if (if_req_i) begin
                if_gnt = 1'b1;
            end
        end
    end

    assign dm_store = dm_gnt && dm_we_i;

    assign if_gnt_o    = if_gnt;
    assign dm_gnt_o    = dm_gnt;
    assign mem_en_o    = if_gnt || dm_gnt;
    assign mem_we_o    = dm_store;
    assign mem_addr_o  = dm_gnt ? dm_addr_i : if_addr_i;
    // Fetch never writes, so write data only ever comes from DM
    assign mem_wdata_o = dm_gnt ? dm_wdata_i : '0;

    // Reads always fetch the full word; only stores honour the byte enables
    generate
        for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_be
            assign mem_be_o[gi] = dm_store ? dm_be_i[gi] : 1'b1;
        end
    endgenerate

    // Next owner of the returning read data and next starvation count
    always_comb begin
        owner_next = OWN_NONE;
        if (if_gnt) begin
            owner_next = OWN_IF;
        end else if (dm_gnt && !dm_we_i) begin
            owner_next = OWN_DM;
        end

        starve_cnt_next = starve_cnt_reg;
        if (!if_req_i || if_gnt) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != STARVE_MAX) begin
            starve_cnt_next = starve_cnt_reg + CNT_W'(1);
        end
    end

    // Response-owner FSM, grant-cycle flush record and starvation counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_reg      <= OWN_NONE;
            flush_q_reg    <= 1'b0;
            starve_cnt_reg <= '0;
        end else begin
            owner_reg      <= owner_next;
            flush_q_reg    <= if_gnt && if_flush_i;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // Steer the RAM output; a flush in either cycle kills the fetch response
    assign if_rvalid_o = !rst_i && (owner_reg == OWN_IF) && !if_flush_i && !flush_q_reg;
    assign dm_rvalid_o = !rst_i && (owner_reg == OWN_DM);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;

`ifdef ARB_PERF_CNT_EN
    mem_arb_perf_cnt u_perf_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .if_stall_i (if_req_i && !if_gnt),
        .dm_stall_i (dm_req_i && !dm_gnt),
        .if_cnt_o   (perf_if_stall_o),
        .dm_cnt_o   (perf_dm_stall_o)
    );
`else
    assign perf_if_stall_o = '0;
    assign perf_dm_stall_o = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a behavioural model
// (priority rules, denied-streak count, shadow memory, pending response).
module tb_mem_port_arbiter;
    import pkg_parameters::*;

    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int LIMIT = ARB_STARVE_LIMIT;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          if_req_i, if_flush_i;
    logic [AW-1:0] if_addr_i;
    logic          if_gnt_o, if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          dm_req_i, dm_we_i;
    logic [BW-1:0] dm_be_i;
    logic [AW-1:0] dm_addr_i;
    logic [DW-1:0] dm_wdata_i;
    logic          dm_gnt_o, dm_rvalid_o;
    logic [DW-1:0] dm_rdata_o;
    logic          mem_en_o, mem_we_o;
    logic [BW-1:0] mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata = '0;
    logic [31:0]   perf_if_stall_o, perf_dm_stall_o;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .if_req_i        (if_req_i),
        .if_addr_i       (if_addr_i),
        .if_flush_i      (if_flush_i),
        .if_gnt_o        (if_gnt_o),
        .if_rvalid_o     (if_rvalid_o),
        .if_rdata_o      (if_rdata_o),
        .dm_req_i        (dm_req_i),
        .dm_we_i         (dm_we_i),
        .dm_be_i         (dm_be_i),
        .dm_addr_i       (dm_addr_i),
        .dm_wdata_i      (dm_wdata_i),
        .dm_gnt_o        (dm_gnt_o),
        .dm_rvalid_o     (dm_rvalid_o),
        .dm_rdata_o      (dm_rdata_o),
        .mem_en_o        (mem_en_o),
        .mem_we_o        (mem_we_o),
        .mem_be_o        (mem_be_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_rdata_i     (mem_rdata),
        .perf_if_stall_o (perf_if_stall_o),
        .perf_dm_stall_o (perf_dm_stall_o)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 'h10)  return 32'h0050_0093;
        if (i == 'h400) return 32'h1122_3344;
        return (DW'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Synchronous RAM seen by the DUT: write with byte enables, read data next cycle
    logic [DW-1:0] ram [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_en_o) begin
                if (mem_we_o) begin
                    for (int b = 0; b < BW; b++)
                        if (mem_be_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                end else begin
                    mem_rdata <= ram[mem_addr_o];
                end
            end
        end
    end

    // ---------------- reference model state ----------------
    logic [DW-1:0] shadow [DEPTH];
    int            streak;        // consecutive cycles fetch asked and was refused
    int            pend_owner;    // 0 none, 1 fetch, 2 load: who gets data next cycle
    logic          pend_flushed;
    logic [DW-1:0] pend_data;
    int unsigned   m_perf_if, m_perf_dm;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    // values seen in the most recent step, for directed checks
    logic          obs_if_gnt, obs_dm_gnt, obs_if_rv, obs_dm_rv, obs_mem_en;
    logic [DW-1:0] obs_if_rd, obs_dm_rd;
    logic [31:0]   obs_perf_if, obs_perf_dm;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic fl,
                         input logic dr, input logic dwe, input logic [BW-1:0] be,
                         input logic [AW-1:0] da, input logic [DW-1:0] wd);
        if_req_i = ir; if_addr_i = ia; if_flush_i = fl;
        dm_req_i = dr; dm_we_i = dwe; dm_be_i = be; dm_addr_i = da; dm_wdata_i = wd;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // One clock cycle: check outputs at the falling edge, then advance the model
    task automatic step();
        logic          e_if_gnt, e_dm_gnt, e_if_rv, e_dm_rv, e_we;
        logic [DW-1:0] e_if_rd, e_dm_rd;
        @(negedge clk);
        e_if_gnt = 1'b0;
        e_dm_gnt = 1'b0;
        if (!rst_i) begin
            if (if_req_i && LIMIT != 0 && streak >= LIMIT) e_if_gnt = 1'b1;
            else if (dm_req_i)                             e_dm_gnt = 1'b1;
            else if (if_req_i)                             e_if_gnt = 1'b1;
        end
        e_if_rv = !rst_i && pend_owner == 1 && !pend_flushed && !if_flush_i;
        e_dm_rv = !rst_i && pend_owner == 2;
        e_if_rd = e_if_rv ? pend_data : '0;
        e_dm_rd = e_dm_rv ? pend_data : '0;
        e_we    = e_dm_gnt && dm_we_i;

        check("if_gnt", 64'(if_gnt_o), 64'(e_if_gnt));
        check("dm_gnt", 64'(dm_gnt_o), 64'(e_dm_gnt));
        check("mem_en", 64'(mem_en_o), 64'(e_if_gnt || e_dm_gnt));
        if (e_if_gnt || e_dm_gnt) begin
            check("mem_we",   64'(mem_we_o),   64'(e_we));
            check("mem_addr", 64'(mem_addr_o), 64'(e_dm_gnt ? dm_addr_i : if_addr_i));
            check("mem_be",   64'(mem_be_o),   64'(e_we ? dm_be_i : {BW{1'b1}}));
            if (e_we) check("mem_wdata", 64'(mem_wdata_o), 64'(dm_wdata_i));
        end
        check("if_rvalid", 64'(if_rvalid_o), 64'(e_if_rv));
        check("if_rdata",  64'(if_rdata_o),  64'(e_if_rd));
        check("dm_rvalid", 64'(dm_rvalid_o), 64'(e_dm_rv));
        check("dm_rdata",  64'(dm_rdata_o),  64'(e_dm_rd));
`ifdef ARB_PERF_CNT_EN
        check("perf_if", 64'(perf_if_stall_o), 64'(m_perf_if));
        check("perf_dm", 64'(perf_dm_stall_o), 64'(m_perf_dm));
`else
        check("perf_if", 64'(perf_if_stall_o), 64'd0);
        check("perf_dm", 64'(perf_dm_stall_o), 64'd0);
`endif
        obs_if_gnt = if_gnt_o;   obs_dm_gnt = dm_gnt_o;
        obs_if_rv  = if_rvalid_o; obs_dm_rv = dm_rvalid_o;
        obs_if_rd  = if_rdata_o;  obs_dm_rd = dm_rdata_o;
        obs_mem_en = mem_en_o;
        obs_perf_if = perf_if_stall_o; obs_perf_dm = perf_dm_stall_o;

        if (e_if_gnt || e_dm_gnt || e_if_rv || e_dm_rv)
            $display("cyc %0d rst=%0d grant=%s addr=%h we=%0d | if_rv=%0d if_rd=%h dm_rv=%0d dm_rd=%h",
                     cyc, rst_i, e_if_gnt ? "IF" : (e_dm_gnt ? "DM" : "--"),
                     e_dm_gnt ? dm_addr_i : if_addr_i, e_we, if_rvalid_o, if_rdata_o,
                     dm_rvalid_o, dm_rdata_o);

        @(posedge clk);
        if (rst_i) begin
            streak = 0; pend_owner = 0; pend_flushed = 1'b0;
            m_perf_if = 0; m_perf_dm = 0;
        end else begin
            if (if_req_i && !e_if_gnt) begin
                m_perf_if++;
                if (streak < LIMIT) streak++;
            end else begin
                streak = 0;
            end
            if (dm_req_i && !e_dm_gnt) m_perf_dm++;
            pend_owner = 0;
            if (e_if_gnt) begin
                pend_owner = 1; pend_data = shadow[if_addr_i]; pend_flushed = if_flush_i;
            end else if (e_dm_gnt && !dm_we_i) begin
                pend_owner = 2; pend_data = shadow[dm_addr_i]; pend_flushed = 1'b0;
            end else if (e_we) begin
                for (int b = 0; b < BW; b++)
                    if (dm_be_i[b]) shadow[dm_addr_i][8*b +: 8] = dm_wdata_i[8*b +: 8];
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        logic [31:0] perf_base;
        logic        hold_if;
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
        streak = 0; pend_owner = 0; pend_flushed = 1'b0; pend_data = '0;
        m_perf_if = 0; m_perf_dm = 0;
        rst_i = 1'b1;
        // requests during reset must not be granted
        drive(1'b1, 14'h10, 1'b0, 1'b1, 1'b0, 4'hF, 14'h400, '0);
        step();
        step();
        rst_i = 1'b0;
        idle();
        step();

        // IF alone
        drive(1'b1, 14'h10, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
        check("ifalone_gnt", 64'(obs_if_gnt), 64'd1);
        idle();
        step();
        check("ifalone_rvalid", 64'(obs_if_rv), 64'd1);
        check("ifalone_rdata",  64'(obs_if_rd), 64'h0050_0093);
        check("ifalone_dm_rv",  64'(obs_dm_rv), 64'd0);

        // Conflict: DM first, IF one cycle later
        drive(1'b1, 14'h20, 1'b0, 1'b1, 1'b0, 4'hF, 14'h400, '0);
        step();
        check("conflict_dm_gnt", 64'(obs_dm_gnt), 64'd1);
        check("conflict_if_wait", 64'(obs_if_gnt), 64'd0);
        drive(1'b1, 14'h20, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
        check("conflict_if_gnt", 64'(obs_if_gnt), 64'd1);
        check("conflict_dm_rv",  64'(obs_dm_rv), 64'd1);
        check("conflict_dm_rd",  64'(obs_dm_rd), 64'h1122_3344);
        idle();
        step();
        check("conflict_if_rv", 64'(obs_if_rv), 64'd1);

        // Store with partial byte enables, then reload
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'b0011, 14'h400, 32'hDEAD_BEEF);
        step();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'hF, 14'h400, '0);
        step();
        check("store_no_rv", 64'(obs_dm_rv), 64'd0);
        idle();
        step();
        check("store_reload", 64'(obs_dm_rd), 64'h1122_BEEF);

        // Starvation: both request for 10 cycles
        perf_base = '0;
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 14'h30, 1'b0, 1'b1, 1'b0, 4'hF, AW'(14'h100 + k), '0);
            step();
            if (k == 1) perf_base = obs_perf_if;
            if (k < 5) check("starve_if_denied", 64'(obs_if_gnt), 64'd0);
            if (k == 5) begin
                check("starve_if_gnt", 64'(obs_if_gnt), 64'd1);
`ifdef ARB_PERF_CNT_EN
                check("starve_perf_if", 64'(obs_perf_if - perf_base), 64'd4);
`endif
            end
            if (k == 6) check("starve_dm_regnt", 64'(obs_dm_gnt), 64'd1);
        end
        idle();
        step();

        // Flush in the grant cycle
        drive(1'b1, 14'h10, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        step();
        check("flush_g_mem_en", 64'(obs_mem_en), 64'd1);
        idle();
        step();
        check("flush_g_rv", 64'(obs_if_rv), 64'd0);
        // Flush in the response cycle
        drive(1'b1, 14'h10, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
        check("flush_r_mem_en", 64'(obs_mem_en), 64'd1);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        step();
        check("flush_r_rv", 64'(obs_if_rv), 64'd0);
        idle();
        step();

        // Reset while a fetch response is due
        drive(1'b1, 14'h10, 1'b0, 1'b1, 1'b0, 4'hF, 14'h20, '0);
        step();
        drive(1'b1, 14'h10, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
        rst_i = 1'b1;
        idle();
        step();
        check("rst_mid_rv", 64'(obs_if_rv), 64'd0);
        rst_i = 1'b0;
        step();
        check("rst_after_rv",  64'(obs_if_rv), 64'd0);
        check("rst_perf_if",   64'(obs_perf_if), 64'd0);
        check("rst_perf_dm",   64'(obs_perf_dm), 64'd0);

        // Randomized traffic: sticky fetch requests, heavy DM load, occasional flush/reset
        hold_if = 1'b0;
        for (int n = 0; n < 400; n++) begin
            rst_i      = ($urandom_range(0, 99) == 0);
            if_req_i   = (hold_if && $urandom_range(0, 9) != 0) || ($urandom_range(0, 1) == 1);
            if (!hold_if) if_addr_i = AW'($urandom_range(0, 63));
            if_flush_i = ($urandom_range(0, 9) == 0);
            dm_req_i   = ($urandom_range(0, 9) < 7);
            dm_we_i    = $urandom_range(0, 1) == 1;
            dm_be_i    = BW'($urandom_range(0, 15));
            dm_addr_i  = ($urandom_range(0, 1) == 1) ? AW'(14'h400 + $urandom_range(0, 7))
                                                     : AW'($urandom_range(0, 63));
            dm_wdata_i = $urandom;
            step();
            hold_if = if_req_i && !obs_if_gnt;
        end
        rst_i = 1'b0;
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
